// File: rtl/noc_interface.sv
// CPU-to-NoC bridge: a TX packet FIFO feeding the router, an RX packet FIFO
// drained by CPU reads, and a small CSR block with sticky error flags and a level irq.
module noc_interface #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        addr_cpu,
  input  logic [DATA_W-1:0]        data_out_cpu,
  output logic [DATA_W-1:0]        data_in_cpu,
  input  logic                     write_en_cpu,
  input  logic                     read_en_cpu,
  input  logic                     csr_sel,
  output logic [ADDR_W+DATA_W-1:0] tx_pkt,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  input  logic [ADDR_W+DATA_W-1:0] rx_pkt,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic                     irq,
  output logic                     tx_full
);

  localparam int PKT_W = ADDR_W + DATA_W;
  localparam int TXP   = $clog2(TX_DEPTH);
  localparam int TXC   = TXP + 1;
  localparam int RXP   = $clog2(RX_DEPTH);
  localparam int RXC   = RXP + 1;

  logic [PKT_W-1:0] tx_mem [TX_DEPTH];
  logic [PKT_W-1:0] rx_mem [RX_DEPTH];
  logic [TXP-1:0]   tx_wr_ptr, tx_rd_ptr;
  logic [RXP-1:0]   rx_wr_ptr, rx_rd_ptr;
  logic [TXC-1:0]   tx_count;
  logic [RXC-1:0]   rx_count;
  logic             tx_ovf, rx_udf, irq_en;

  logic             cpu_wr, cpu_rd;
  logic             tx_push, tx_pop, tx_drop;
  logic             rx_push, rx_pop, rx_empty, rx_read_udf;
  logic             csr_wr_status, csr_wr_irq;
  logic [PKT_W-1:0] rx_head;
  logic [31:0]      status_word;
  logic [DATA_W-1:0] rd_data;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; the offering side holds its payload until that edge.
  assign cpu_wr   = write_en_cpu;
  assign cpu_rd   = read_en_cpu & ~write_en_cpu;

  assign tx_full  = (tx_count == TXC'(TX_DEPTH));
  assign tx_valid = (tx_count != '0);
  assign tx_pkt   = tx_mem[tx_rd_ptr];
  assign tx_push  = cpu_wr & ~csr_sel & ~tx_full;
  assign tx_drop  = cpu_wr & ~csr_sel & tx_full;
  assign tx_pop   = tx_valid & tx_ready;

  assign rx_ready    = (rx_count != RXC'(RX_DEPTH));
  assign rx_empty    = (rx_count == '0);
  assign rx_head     = rx_mem[rx_rd_ptr];
  assign rx_push     = rx_valid & rx_ready;
  assign rx_pop      = cpu_rd & ~csr_sel & ~rx_empty;
  assign rx_read_udf = cpu_rd & ~csr_sel & rx_empty;

  assign csr_wr_status = cpu_wr & csr_sel & ~addr_cpu[2];
  assign csr_wr_irq    = cpu_wr & csr_sel & addr_cpu[2];

  assign status_word = {8'h00, 8'(rx_count), 8'(tx_count), 1'b0, irq_en, rx_udf,
                        tx_ovf, ~rx_empty, rx_ready, tx_valid, tx_full};

  always_comb begin
    rd_data = data_in_cpu;
    if (cpu_rd) begin
      if (!csr_sel)
        rd_data = rx_empty ? '0 : rx_head[DATA_W-1:0];
      else if (addr_cpu[2])
        rd_data = rx_empty ? '0 : DATA_W'(rx_head[PKT_W-1:DATA_W]);
      else
        rd_data = DATA_W'(status_word);
    end
  end

  // Storage is deliberately left out of reset; only pointers and counts matter.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= {addr_cpu, data_out_cpu};
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_pkt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wr_ptr   <= '0;
      tx_rd_ptr   <= '0;
      tx_count    <= '0;
      rx_wr_ptr   <= '0;
      rx_rd_ptr   <= '0;
      rx_count    <= '0;
      tx_ovf      <= 1'b0;
      rx_udf      <= 1'b0;
      irq_en      <= 1'b0;
      irq         <= 1'b0;
      data_in_cpu <= '0;
    end else begin
      tx_wr_ptr   <= tx_wr_ptr + TXP'(tx_push);
      tx_rd_ptr   <= tx_rd_ptr + TXP'(tx_pop);
      tx_count    <= tx_count + TXC'(tx_push) - TXC'(tx_pop);
      rx_wr_ptr   <= rx_wr_ptr + RXP'(rx_push);
      rx_rd_ptr   <= rx_rd_ptr + RXP'(rx_pop);
      rx_count    <= rx_count + RXC'(rx_push) - RXC'(rx_pop);
      data_in_cpu <= rd_data;

      // Set events take priority over write-1-to-clear.
      if (tx_drop)
        tx_ovf <= 1'b1;
      else if (csr_wr_status && data_out_cpu[4])
        tx_ovf <= 1'b0;
      if (rx_read_udf)
        rx_udf <= 1'b1;
      else if (csr_wr_status && data_out_cpu[5])
        rx_udf <= 1'b0;

      if (csr_wr_irq) irq_en <= data_out_cpu[0];
      irq <= irq_en & (~rx_empty | tx_ovf | rx_udf);
    end
  end

endmodule

// File: tb/tb_noc_interface.sv
// Self-checking bench for noc_interface: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_noc_interface;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TD = 8;
  localparam int RD = 8;
  localparam int PW = AW + DW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] addr_cpu = '0;
  logic [DW-1:0] data_out_cpu = '0;
  logic [DW-1:0] data_in_cpu;
  logic          write_en_cpu = 1'b0;
  logic          read_en_cpu = 1'b0;
  logic          csr_sel = 1'b0;
  logic [PW-1:0] tx_pkt;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic [PW-1:0] rx_pkt = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          irq;
  logic          tx_full;

  always #5 clk = ~clk;

  noc_interface #(.ADDR_W(AW), .DATA_W(DW), .TX_DEPTH(TD), .RX_DEPTH(RD)) dut (
    .clk(clk), .reset(reset), .addr_cpu(addr_cpu), .data_out_cpu(data_out_cpu),
    .data_in_cpu(data_in_cpu), .write_en_cpu(write_en_cpu), .read_en_cpu(read_en_cpu),
    .csr_sel(csr_sel), .tx_pkt(tx_pkt), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_pkt(rx_pkt), .rx_valid(rx_valid), .rx_ready(rx_ready), .irq(irq), .tx_full(tx_full)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model
  logic [PW-1:0] tx_exp_q[$];
  logic [PW-1:0] rx_exp_q[$];
  bit            m_ovf = 0, m_udf = 0, m_irq_en = 0, m_irq = 0;
  logic [DW-1:0] m_dout = '0;
  int            m_tn, m_rn;
  bit            m_wr, m_rd, m_nirq;
  logic [31:0]   m_st;
  logic [PW-1:0] m_tmp;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_exp_q.delete();
      rx_exp_q.delete();
      m_ovf = 0; m_udf = 0; m_irq_en = 0; m_irq = 0; m_dout = '0;
    end else begin
      m_tn = tx_exp_q.size();
      m_rn = rx_exp_q.size();
      m_wr = write_en_cpu;
      m_rd = read_en_cpu && !write_en_cpu;
      m_nirq = m_irq_en && (m_rn > 0 || m_ovf || m_udf);
      m_st = '0;
      m_st[0] = (m_tn == TD);
      m_st[1] = (m_tn > 0);
      m_st[2] = (m_rn < RD);
      m_st[3] = (m_rn > 0);
      m_st[4] = m_ovf;
      m_st[5] = m_udf;
      m_st[6] = m_irq_en;
      m_st[15:8] = 8'(m_tn);
      m_st[23:16] = 8'(m_rn);

      if (m_tn > 0 && tx_ready) void'(tx_exp_q.pop_front());
      if (m_wr && !csr_sel) begin
        if (m_tn < TD) tx_exp_q.push_back({addr_cpu, data_out_cpu});
        else m_ovf = 1;
      end
      if (m_wr && csr_sel) begin
        if (addr_cpu[2]) m_irq_en = data_out_cpu[0];
        else begin
          if (data_out_cpu[4]) m_ovf = 0;
          if (data_out_cpu[5]) m_udf = 0;
        end
      end
      if (m_rd) begin
        if (!csr_sel) begin
          if (m_rn > 0) begin
            m_tmp = rx_exp_q.pop_front();
            m_dout = m_tmp[DW-1:0];
          end else begin
            m_dout = '0;
            m_udf = 1;
          end
        end else if (addr_cpu[2]) begin
          m_tmp = (m_rn > 0) ? rx_exp_q[0] : '0;
          m_dout = m_tmp[PW-1:DW];
        end else begin
          m_dout = m_st;
        end
      end
      if (rx_valid && m_rn < RD) rx_exp_q.push_back(rx_pkt);
      m_irq = m_nirq;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("tx_valid", tx_valid, tx_exp_q.size() > 0);
      if (tx_exp_q.size() > 0) check("tx_pkt", tx_pkt, tx_exp_q[0]);
      check("tx_full", tx_full, tx_exp_q.size() == TD);
      check("rx_ready", rx_ready, rx_exp_q.size() < RD);
      check("irq", irq, m_irq);
      check("data_in_cpu", data_in_cpu, m_dout);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic cpu_write(input bit csr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    write_en_cpu = 1'b1; csr_sel = csr; addr_cpu = a; data_out_cpu = d;
    step();
    write_en_cpu = 1'b0;
  endtask

  task automatic cpu_read(input bit csr, input logic [AW-1:0] a);
    read_en_cpu = 1'b1; csr_sel = csr; addr_cpu = a;
    step();
    read_en_cpu = 1'b0;
  endtask

  initial begin
    int pt, pr, pw;
    @(negedge clk);
    #1;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_full", tx_full, 0);
    check("rst_rx_ready", rx_ready, 1);
    check("rst_irq", irq, 0);
    check("rst_data_in", data_in_cpu, 0);
    step();
    reset = 1'b0;
    chk_en = 1'b1;

    // In-order TX delivery with router always ready
    tx_ready = 1'b1;
    cpu_write(0, 'h10, 'hA);
    check("tx_order0", tx_pkt, 64'h00000010_0000000A);
    cpu_write(0, 'h20, 'hB);
    check("tx_order1", tx_pkt, 64'h00000020_0000000B);
    cpu_write(0, 'h30, 'hC);
    check("tx_order2", tx_pkt, 64'h00000030_0000000C);
    step();
    check("tx_drained", tx_valid, 0);
    tx_ready = 1'b0;

    // Overflow: TD+1 pushes with router stalled
    for (int i = 0; i <= TD; i++) begin
      cpu_write(0, AW'(i), DW'(i + 100));
      if (i == TD - 1) check("tx_full_at_depth", tx_full, 1);
    end
    cpu_read(1, 0);
    check("ovf_bit", data_in_cpu[4], 1);
    check("ovf_count", data_in_cpu[15:8], TD);
    cpu_write(1, 0, 'h10);
    cpu_read(1, 0);
    check("ovf_cleared", data_in_cpu[4], 0);
    tx_ready = 1'b1;
    repeat (TD) step();
    tx_ready = 1'b0;
    check("tx_empty_after_drain", tx_valid, 0);

    // RX path, CSR peek, FIFO read, underflow
    rx_pkt = {32'h55, 32'h1234};
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    cpu_read(1, 4);
    check("rx_head_addr", data_in_cpu, 'h55);
    cpu_read(0, 0);
    check("rx_fifo_data", data_in_cpu, 'h1234);
    cpu_read(1, 0);
    check("rx_count_zero", data_in_cpu[23:16], 0);
    cpu_read(0, 0);
    check("rx_empty_read", data_in_cpu, 0);
    cpu_read(1, 0);
    check("udf_bit", data_in_cpu[5], 1);
    cpu_write(1, 0, 'h20);

    // irq follows RX occupancy one cycle late
    cpu_write(1, 4, 1);
    rx_pkt = {$urandom, $urandom};
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    check("irq_push_edge", irq, 0);
    step();
    check("irq_raised", irq, 1);
    cpu_read(0, 0);
    step();
    check("irq_dropped", irq, 0);
    cpu_write(1, 4, 0);

    // Push into full FIFO while a pop happens is refused
    for (int i = 0; i < TD; i++) cpu_write(0, $urandom, $urandom);
    check("full_before_race", tx_full, 1);
    tx_ready = 1'b1;
    cpu_write(0, 'hDEAD, 'hBEEF);
    tx_ready = 1'b0;
    cpu_read(1, 0);
    check("race_count", data_in_cpu[15:8], TD - 1);
    check("race_ovf", data_in_cpu[4], 1);
    cpu_write(1, 0, 'h10);
    tx_ready = 1'b1;
    repeat (TD) step();
    tx_ready = 1'b0;

    // Asynchronous reset with both FIFOs half full
    for (int i = 0; i < TD / 2; i++) cpu_write(0, $urandom, $urandom);
    rx_valid = 1'b1;
    for (int i = 0; i < RD / 2; i++) begin
      rx_pkt = {$urandom, $urandom};
      step();
    end
    rx_valid = 1'b0;
    cpu_read(1, 0);
    check("half_status", data_in_cpu, 32'h0004_040E);
    reset = 1'b1;
    #1;
    check("arst_tx_valid", tx_valid, 0);
    check("arst_tx_full", tx_full, 0);
    check("arst_rx_ready", rx_ready, 1);
    check("arst_irq", irq, 0);
    check("arst_data_in", data_in_cpu, 0);
    step();
    reset = 1'b0;
    cpu_read(1, 0);
    check("post_reset_status", data_in_cpu, 32'h4);

    // Randomized traffic in segments with varying pressure
    for (int s = 0; s < 6; s++) begin
      pt = $urandom_range(5, 95);
      pr = $urandom_range(5, 95);
      pw = $urandom_range(10, 70);
      for (int c = 0; c < 400; c++) begin
        tx_ready     = ($urandom_range(0, 99) < pt);
        rx_valid     = ($urandom_range(0, 99) < pr);
        rx_pkt       = {$urandom, $urandom};
        write_en_cpu = ($urandom_range(0, 99) < pw);
        read_en_cpu  = ($urandom_range(0, 99) < 50);
        csr_sel      = ($urandom_range(0, 3) == 0);
        addr_cpu     = $urandom;
        data_out_cpu = $urandom;
        step();
      end
    end
    write_en_cpu = 1'b0;
    read_en_cpu  = 1'b0;
    rx_valid     = 1'b0;
    tx_ready     = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
